mem_stage: RTL and testbench
============================

# mem_stage

Pipeline MEM stage of the five-stage processor, directly downstream of the execute stage and its EX/MEM register. Consumes the registered execute results, performs loads/stores on the data memory over a variable-latency req/ack bus, stalls the front of the pipeline while an access is outstanding, and owns the MEM/WB pipeline register feeding write-back. Also exports the MEM-side forwarding signals consumed by the execute stage's forwarding unit.

## Interface
Parameters:
- TIMEOUT, 16, max cycles spent in WAIT before an access is aborted (≥2)
- CNT_W, 5, width of the wait counter (must hold TIMEOUT)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- MemRead  in  1  load in EX/MEM
- MemWrite  in  1  store in EX/MEM
- RegWrite  in  1  instruction writes a register
- MemtoReg  in  1  write-back selects memory data
- alu  in  32  ALU result / effective address
- readdata2  in  32  forwarded store data
- mux  in  5  destination register
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  word address = alu
- dmem_wdata  out  32  = readdata2
- dmem_ack  in  1  single-cycle completion strobe
- dmem_rdata  in  32  read data, valid with dmem_ack
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- MEMRegRd  out  5  = mux (forwarding)
- MEM_RegWrite  out  1  = RegWrite (forwarding)
- regExMem  out  32  = alu (forwarding)
- RegWrite_out  out  1  MEM/WB
- MemtoReg_out  out  1  MEM/WB
- readdata_out  out  32  MEM/WB load data
- alu_out  out  32  MEM/WB ALU result
- mux_out  out  5  MEM/WB destination
- align_error  out  1  one-cycle pulse, misaligned access dropped
- bus_error  out  1  sticky, set on timeout, cleared only by reset

## Operation
- memop = (MemRead | MemWrite) & (alu[1:0] == 0). MemWrite has priority if both set (dmem_we = MemWrite).
- Misaligned (MemRead|MemWrite with alu[1:0] != 0): no request, align_error = 1 next cycle, MEM/WB loads a bubble, no stall.
- FSM, two states:
  - IDLE: dmem_req = memop. If memop & dmem_ack: access completes this cycle, MEM/WB loads instruction. If memop & !dmem_ack: go WAIT, counter ← 1. No memop: MEM/WB loads instruction (non-memory ops pass through).
  - WAIT: dmem_req = 1. On dmem_ack: MEM/WB loads instruction, → IDLE. Else if counter == TIMEOUT: bus_error ← 1, MEM/WB loads bubble, → IDLE. Else counter + 1.
- stall = dmem_req & !dmem_ack & !(state == WAIT & counter == TIMEOUT). Combinational.
- While stall = 1, MEM/WB loads a bubble (RegWrite_out = 0, MemtoReg_out = 0; data fields don't-care). EX/MEM inputs are held stable by upstream.
- Bubble: RegWrite_out = 0, MemtoReg_out = 0, mux_out = 0.
- readdata_out ← dmem_rdata on completing loads; holds previous value otherwise.
- dmem_ack with dmem_req = 0 is ignored.

## Timing
- Reset (RST = 0): state IDLE, counter 0, all MEM/WB outputs 0, align_error 0, bus_error 0. dmem_req/stall fall immediately as combinational functions of reset state; reset mid-WAIT abandons the access with no MEM/WB update.
- Zero-wait access: req and ack same cycle, no stall, result in MEM/WB at next edge (1-cycle latency, as non-memory ops).
- N-wait access (ack N cycles after req first asserted): stall high N cycles, N bubbles into MEM/WB, result registered at edge ending ack cycle.
- Timeout: stall high exactly TIMEOUT cycles; stall low in the abort cycle so the pipeline advances; instruction is discarded.
- Forwarding outputs are combinational from EX/MEM inputs, valid every cycle including stalls.

## Test plan
- Reset: assert RST = 0 mid-WAIT → dmem_req = 0, stall = 0, all outputs 0; release, FSM in IDLE.
- Zero-wait load: MemRead = 1, alu = 0x40, ack same cycle with rdata = 0xDEADBEEF → stall never 1; next edge readdata_out = 0xDEADBEEF, alu_out = 0x40, RegWrite_out = 1, MemtoReg_out = 1.
- Store with 3 wait cycles: MemWrite = 1, alu = 0x100, readdata2 = 0x12345678 → dmem_we = 1, dmem_wdata = 0x12345678, stall = 1 for 3 cycles, 3 bubbles in MEM/WB, then RegWrite_out = 0, stall drops.
- Misaligned load alu = 0x42 → dmem_req = 0, align_error pulses 1 cycle, MEM/WB bubble, no stall.
- Timeout: MemRead, ack never asserted, TIMEOUT = 16 → stall high 16 cycles, then bus_error = 1 (stays until reset), bubble written, next instruction proceeds.
- Back-to-back: ADD (RegWrite, alu = 7, mux = 3) then 1-wait load → forwarding outputs MEMRegRd = 3, regExMem = 7 during ADD cycle; ADD reaches MEM/WB without stall; load stalls exactly 1 cycle.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: data-memory access over a variable-latency req/ack bus, pipeline
// stall while an access is outstanding, timeout abort, and the MEM/WB register.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [31:0] alu,
    input  logic [31:0] readdata2,
    input  logic [4:0]  mux,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [4:0]  MEMRegRd,
    output logic        MEM_RegWrite,
    output logic [31:0] regExMem,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] readdata_out,
    output logic [31:0] alu_out,
    output logic [4:0]  mux_out,
    output logic        align_error,
    output logic        bus_error
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             rw_q, rw_d;
    logic             m2r_q, m2r_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      alu_q, alu_d;
    logic [4:0]       dst_q, dst_d;
    logic             align_q, align_d;
    logic             bus_q, bus_d;

    logic             memacc;
    logic             memop;
    logic             misalign;
    logic             timeout_hit;
    logic             complete;
    logic             load_instr;
    logic             is_load;

    assign memacc      = MemRead | MemWrite;
    assign memop       = memacc & (alu[1:0] == 2'b00);
    assign misalign    = memacc & (alu[1:0] != 2'b00);
    assign is_load     = MemRead & ~MemWrite;
    assign timeout_hit = (state_q == S_WAIT) && (cnt_q == TIMEOUT_C);

    // Request is gated by reset so an abandoned access drops off the bus at once.
    assign dmem_req   = RST & ((state_q == S_WAIT) | memop);
    assign dmem_we    = MemWrite;
    assign dmem_addr  = alu;
    assign dmem_wdata = readdata2;
    assign complete   = dmem_req & dmem_ack;
    assign stall      = dmem_req & ~dmem_ack & ~timeout_hit;

    assign MEMRegRd     = mux;
    assign MEM_RegWrite = RegWrite;
    assign regExMem     = alu;

    assign RegWrite_out = rw_q;
    assign MemtoReg_out = m2r_q;
    assign readdata_out = rdata_q;
    assign alu_out      = alu_q;
    assign mux_out      = dst_q;
    assign align_error  = align_q;
    assign bus_error    = bus_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        align_d    = 1'b0;
        bus_d      = bus_q;
        load_instr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (memop) begin
                    if (dmem_ack) begin
                        load_instr = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (misalign) begin
                    align_d = 1'b1;
                end else begin
                    load_instr = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    load_instr = 1'b1;
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                end else if (timeout_hit) begin
                    bus_d   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MEM/WB next state: either the instruction or a bubble; data fields hold on bubbles.
    always_comb begin
        rw_d    = 1'b0;
        m2r_d   = 1'b0;
        dst_d   = 5'd0;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        if (load_instr) begin
            rw_d  = RegWrite;
            m2r_d = MemtoReg;
            dst_d = mux;
            alu_d = alu;
            if (complete && is_load) begin
                rdata_d = dmem_rdata;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            rdata_q <= '0;
            alu_q   <= '0;
            dst_q   <= '0;
            align_q <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            m2r_q   <= m2r_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            dst_q   <= dst_d;
            align_q <= align_d;
            bus_q   <= bus_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model with randomized
// instructions and bus latencies, plus directed scenarios with literal expectations.
module tb_mem_stage;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic        CLK;
    logic        RST;
    logic        MemRead, MemWrite, RegWrite, MemtoReg;
    logic [31:0] alu, readdata2;
    logic [4:0]  mux;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [4:0]  MEMRegRd;
    logic        MEM_RegWrite;
    logic [31:0] regExMem;
    logic        RegWrite_out, MemtoReg_out;
    logic [31:0] readdata_out, alu_out;
    logic [4:0]  mux_out;
    logic        align_error, bus_error;

    mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .alu(alu), .readdata2(readdata2), .mux(mux),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .MEMRegRd(MEMRegRd), .MEM_RegWrite(MEM_RegWrite), .regExMem(regExMem),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .readdata_out(readdata_out),
        .alu_out(alu_out), .mux_out(mux_out), .align_error(align_error), .bus_error(bus_error)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_pass  = 0;
    int n_total = 0;
    int stall_cnt = 0;
    bit chk_en = 1'b0;

    // Expected combinational outputs for the current cycle.
    bit exp_req, exp_stall, exp_we;
    // Model of the MEM/WB register and status flags.
    bit          m_rw, m_m2r, m_align, m_bus, m_valid;
    logic [31:0] m_rd, m_alu;
    logic [4:0]  m_dst;
    // Values the model will take at the next edge.
    bit          nx_rw, nx_m2r, nx_align, nx_bus, nx_valid;
    logic [31:0] nx_rd, nx_alu;
    logic [4:0]  nx_dst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            if (stall === 1'b1) stall_cnt++;
            chk("stall", {31'd0, stall}, {31'd0, exp_stall});
            chk("dmem_req", {31'd0, dmem_req}, {31'd0, exp_req});
            if (exp_req) chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
            chk("dmem_addr", dmem_addr, alu);
            chk("dmem_wdata", dmem_wdata, readdata2);
            chk("MEMRegRd", {27'd0, MEMRegRd}, {27'd0, mux});
            chk("MEM_RegWrite", {31'd0, MEM_RegWrite}, {31'd0, RegWrite});
            chk("regExMem", regExMem, alu);
            chk("RegWrite_out", {31'd0, RegWrite_out}, {31'd0, m_rw});
            chk("MemtoReg_out", {31'd0, MemtoReg_out}, {31'd0, m_m2r});
            chk("mux_out", {27'd0, mux_out}, {27'd0, m_dst});
            chk("readdata_out", readdata_out, m_rd);
            if (m_valid) chk("alu_out", alu_out, m_alu);
            chk("align_error", {31'd0, align_error}, {31'd0, m_align});
            chk("bus_error", {31'd0, bus_error}, {31'd0, m_bus});
        end
    end

    task automatic model_reset();
        m_rw = 0; m_m2r = 0; m_align = 0; m_bus = 0; m_valid = 1;
        m_rd = '0; m_alu = '0; m_dst = '0;
    endtask

    // One instruction held in EX/MEM until it leaves the stage. n = cycles from
    // first request until the memory acknowledges (n > TIMEOUT means never).
    task automatic run_instr(input bit mr, input bit mw, input bit rw, input bit m2r,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input logic [4:0] d, input int n);
        bit mo, mis;
        int kend;
        mo   = (mr | mw) && (a[1:0] == 2'b00);
        mis  = (mr | mw) && (a[1:0] != 2'b00);
        kend = mo ? ((n < TIMEOUT) ? n : TIMEOUT) : 0;
        for (int k = 0; k <= kend; k++) begin
            MemRead = mr; MemWrite = mw; RegWrite = rw; MemtoReg = m2r;
            alu = a; readdata2 = wd; mux = d;
            if (mo) dmem_ack = (k == n);
            else    dmem_ack = $urandom_range(1, 0) == 1;
            dmem_rdata = dmem_ack && mo ? rd : $urandom;
            exp_req   = mo;
            exp_we    = mw;
            exp_stall = mo && (k < n) && (k < TIMEOUT);

            nx_rw = 0; nx_m2r = 0; nx_dst = '0; nx_align = 0;
            nx_bus = m_bus; nx_rd = m_rd; nx_alu = m_alu; nx_valid = 0;
            if (k == kend) begin
                if (mo && n > TIMEOUT) begin
                    nx_bus = 1;
                end else if (mis) begin
                    nx_align = 1;
                end else begin
                    nx_rw = rw; nx_m2r = m2r; nx_dst = d; nx_alu = a; nx_valid = 1;
                    if (mo && mr && !mw) nx_rd = rd;
                end
            end

            @(posedge CLK);
            #1;
            m_rw = nx_rw; m_m2r = nx_m2r; m_dst = nx_dst; m_align = nx_align;
            m_bus = nx_bus; m_rd = nx_rd; m_alu = nx_alu; m_valid = nx_valid;
        end
    endtask

    task automatic run_random(input int count);
        for (int i = 0; i < count; i++) begin
            int kind, n;
            bit mr, mw;
            logic [31:0] a;
            kind = $urandom_range(5, 0);
            a = $urandom;
            mr = 0; mw = 0;
            case (kind)
                0: ;
                1, 2: mr = 1;
                3: mw = 1;
                4: begin mr = 1; mw = 1; end
                default: begin
                    mr = $urandom_range(1, 0) == 1;
                    mw = !mr;
                end
            endcase
            if (kind == 5) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
            end else if (kind != 0) begin
                a[1:0] = 2'b00;
            end
            if ($urandom_range(19, 0) == 0) n = $urandom_range(TIMEOUT + 2, TIMEOUT - 1);
            else                            n = $urandom_range(4, 0);
            run_instr(mr, mw, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
                      a, $urandom, $urandom, 5'($urandom), n);
        end
    endtask

    initial begin
        int s0;
        RST = 1'b0;
        MemRead = 0; MemWrite = 0; RegWrite = 0; MemtoReg = 0;
        alu = '0; readdata2 = '0; mux = '0; dmem_ack = 0; dmem_rdata = '0;
        exp_req = 0; exp_stall = 0; exp_we = 0;
        model_reset();

        #2;
        chk("reset RegWrite_out", {31'd0, RegWrite_out}, 32'd0);
        chk("reset readdata_out", readdata_out, 32'd0);
        chk("reset bus_error", {31'd0, bus_error}, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk_en = 1'b1;

        // Zero-wait load.
        s0 = stall_cnt;
        run_instr(1, 0, 1, 1, 32'h40, 32'h0, 32'hDEADBEEF, 5'd9, 0);
        chk("zw stalls", stall_cnt - s0, 0);
        chk("zw readdata_out", readdata_out, 32'hDEADBEEF);
        chk("zw alu_out", alu_out, 32'h40);
        chk("zw RegWrite_out", {31'd0, RegWrite_out}, 32'd1);
        chk("zw MemtoReg_out", {31'd0, MemtoReg_out}, 32'd1);

        // Store with three wait cycles.
        s0 = stall_cnt;
        run_instr(0, 1, 0, 0, 32'h100, 32'h12345678, 32'h0, 5'd0, 3);
        chk("st stalls", stall_cnt - s0, 3);
        chk("st RegWrite_out", {31'd0, RegWrite_out}, 32'd0);

        // Misaligned load.
        s0 = stall_cnt;
        run_instr(1, 0, 1, 1, 32'h42, 32'h0, 32'h0, 5'd4, 0);
        chk("mis stalls", stall_cnt - s0, 0);
        chk("mis align_error", {31'd0, align_error}, 32'd1);
        chk("mis RegWrite_out", {31'd0, RegWrite_out}, 32'd0);

        // Timeout, then an ordinary instruction proceeds.
        s0 = stall_cnt;
        run_instr(1, 0, 1, 1, 32'h200, 32'h0, 32'h0, 5'd5, 100);
        chk("to stalls", stall_cnt - s0, TIMEOUT);
        chk("to bus_error", {31'd0, bus_error}, 32'd1);
        chk("to RegWrite_out", {31'd0, RegWrite_out}, 32'd0);

        // ADD then a one-wait load.
        run_instr(0, 0, 1, 0, 32'd7, 32'h0, 32'h0, 5'd3, 0);
        chk("add mux_out", {27'd0, mux_out}, 32'd3);
        chk("add alu_out", alu_out, 32'd7);
        chk("add bus_error sticky", {31'd0, bus_error}, 32'd1);
        s0 = stall_cnt;
        run_instr(1, 0, 1, 1, 32'h80, 32'h0, 32'hCAFEF00D, 5'd6, 1);
        chk("ld1 stalls", stall_cnt - s0, 1);
        chk("ld1 readdata_out", readdata_out, 32'hCAFEF00D);

        run_random(300);

        // Reset in the middle of a wait.
        chk_en = 1'b0;
        MemRead = 1; MemWrite = 0; RegWrite = 1; MemtoReg = 1;
        alu = 32'h300; mux = 5'd7; dmem_ack = 0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("pre-reset stall", {31'd0, stall}, 32'd1);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst RegWrite_out", {31'd0, RegWrite_out}, 32'd0);
        chk("rst MemtoReg_out", {31'd0, MemtoReg_out}, 32'd0);
        chk("rst readdata_out", readdata_out, 32'd0);
        chk("rst alu_out", alu_out, 32'd0);
        chk("rst mux_out", {27'd0, mux_out}, 32'd0);
        chk("rst align_error", {31'd0, align_error}, 32'd0);
        chk("rst bus_error", {31'd0, bus_error}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        MemRead = 0; RegWrite = 0; MemtoReg = 0; alu = '0; mux = '0;
        model_reset();
        @(posedge CLK); #1;
        chk_en = 1'b1;

        s0 = stall_cnt;
        run_instr(1, 0, 1, 1, 32'h44, 32'h0, 32'h0BADF00D, 5'd2, 2);
        chk("post-rst stalls", stall_cnt - s0, 2);
        chk("post-rst readdata_out", readdata_out, 32'h0BADF00D);

        run_random(100);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
